// File: rtl/yu_core_pkg.sv
// ============================================================================
// Module  : yu_core_pkg
// Brief   : Shared next-PC select codes, fetch state encoding and NOP word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package yu_core_pkg;

  typedef enum logic [1:0] {
    PC_SEL_SEQ    = 2'b00,
    PC_SEL_BRANCH = 2'b01,
    PC_SEL_JUMP   = 2'b10,
    PC_SEL_TRAP   = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/mux4.sv
// ============================================================================
// Module  : mux4
// Brief   : Generic parameterised 4-input multiplexer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4 #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pc_next_sel.sv
// ============================================================================
// Module  : pc_next_sel
// Brief   : Combinational 4-way next-PC select with word-alignment check.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_sel
  import yu_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pc_select,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jump_target,
  input  logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_jump_pc;
  logic [XLEN-1:0] w_trap_pc;

  assign w_pc_plus4 = pc + XLEN'(4);
  assign w_jump_pc  = jump_target & ~XLEN'(1);
  assign w_trap_pc  = trap_vector & ~XLEN'(3);

  mux4 #(
    .WIDTH (XLEN)
  ) u_mux (
    .sel (pc_select),
    .d0  (w_pc_plus4),
    .d1  (branch_target),
    .d2  (w_jump_pc),
    .d3  (w_trap_pc),
    .y   (next_pc)
  );

  // The trap vector is trusted as-is; only computed targets are checked.
  assign misaligned = (next_pc[1:0] != 2'b00) && (pc_select != PC_SEL_TRAP);

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module  : pc_fetch_unit
// Brief   : PC register, fetch sequencer and retired-instruction counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
  import yu_core_pkg::*;
#(
  parameter int                XLEN          = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR  = '0,
  parameter int                INSTRET_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               pc_select,
  input  logic [XLEN-1:0]          branch_target,
  input  logic [XLEN-1:0]          jump_target,
  input  logic [XLEN-1:0]          trap_vector,
  input  logic                     commit,
  input  logic                     stall,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_ready,
  input  logic [31:0]              imem_rdata,
  output logic                     inst_valid,
  output logic [31:0]              inst,
  output logic [XLEN-1:0]          pc,
  output logic                     misalign_exc,
  output logic [INSTRET_WIDTH-1:0] instret
);

  fetch_state_e             r_state;
  logic [XLEN-1:0]          r_pc;
  logic                     r_imem_req;
  logic                     r_inst_valid;
  logic [31:0]              r_inst;
  logic                     r_misalign_exc;
  logic [INSTRET_WIDTH-1:0] r_instret;

  logic [XLEN-1:0]          w_next_pc;
  logic                     w_misaligned;
  logic [XLEN-1:0]          w_trap_pc;
  logic                     w_accept;

  pc_next_sel #(
    .XLEN (XLEN)
  ) u_next_sel (
    .pc            (r_pc),
    .pc_select     (pc_select),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .trap_vector   (trap_vector),
    .next_pc       (w_next_pc),
    .misaligned    (w_misaligned)
  );

  assign w_trap_pc = trap_vector & ~XLEN'(3);
  assign w_accept  = (r_state == VALID) && commit && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_pc           <= RESET_VECTOR;
      r_imem_req     <= 1'b0;
      r_inst_valid   <= 1'b0;
      r_inst         <= NOP_INSTR;
      r_misalign_exc <= 1'b0;
      r_instret      <= '0;
    end else begin
      r_misalign_exc <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state    <= FETCH;
          r_imem_req <= 1'b1;
        end
        FETCH: begin
          if (r_imem_req && imem_ready) begin
            r_inst       <= imem_rdata;
            r_imem_req   <= 1'b0;
            r_inst_valid <= 1'b1;
            r_state      <= VALID;
          end
        end
        VALID: begin
          if (w_accept) begin
            // A misaligned computed target redirects to the trap handler.
            r_pc           <= w_misaligned ? w_trap_pc : w_next_pc;
            r_misalign_exc <= w_misaligned;
            r_instret      <= r_instret + INSTRET_WIDTH'(1);
            r_inst_valid   <= 1'b0;
            r_imem_req     <= 1'b1;
            r_state        <= FETCH;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_imem_req   <= 1'b0;
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req     = r_imem_req;
  assign imem_addr    = r_pc;
  assign inst_valid   = r_inst_valid;
  assign inst         = r_inst;
  assign pc           = r_pc;
  assign misalign_exc = r_misalign_exc;
  assign instret      = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module  : tb_pc_fetch_unit
// Brief   : Scoreboard bench for pc_fetch_unit with directed commit vectors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

  localparam int IRW = 4;

  logic           clk;
  logic           rst_n;
  logic [1:0]     sel;
  logic [31:0]    br_t;
  logic [31:0]    jmp_t;
  logic [31:0]    trap_v;
  logic           commit;
  logic           stall;
  logic           imem_req;
  logic [31:0]    imem_addr;
  logic           rdy;
  logic [31:0]    imem_rdata;
  logic           inst_valid;
  logic [31:0]    inst;
  logic [31:0]    pc;
  logic           misalign_exc;
  logic [IRW-1:0] instret;

  typedef struct {
    logic [31:0]    pc;
    logic [31:0]    inst;
    logic [IRW-1:0] ir;
  } exp_t;

  exp_t           q[$];
  int             total = 0;
  int             bad   = 0;
  logic [IRW-1:0] exp_ir = '0;
  logic           prev_valid = 1'b0;

  pc_fetch_unit #(
    .XLEN          (32),
    .RESET_VECTOR  (32'h0000_0000),
    .INSTRET_WIDTH (IRW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_select     (sel),
    .branch_target (br_t),
    .jump_target   (jmp_t),
    .trap_vector   (trap_v),
    .commit        (commit),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (rdy),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .pc            (pc),
    .misalign_exc  (misalign_exc),
    .instret       (instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory returns an address-dependent word when ready, garbage otherwise.
  always_comb begin
    imem_rdata = rdy ? (32'h0050_0093 + imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (inst_valid && !prev_valid) begin
        if (q.size() == 0) begin
          check("unexpected inst_valid", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("mon pc", 64'(pc), 64'(e.pc));
          check("mon inst", 64'(inst), 64'(e.inst));
          check("mon instret", 64'(instret), 64'(e.ir));
        end
      end
      prev_valid = inst_valid;
    end
  end

  task automatic push_exp(input logic [31:0] p);
    exp_t e;
    e.pc   = p;
    e.inst = 32'h0050_0093 + p;
    e.ir   = exp_ir;
    q.push_back(e);
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("wait_valid timeout", 64'd0, 64'd1);
  endtask

  task automatic do_commit(input logic [1:0] s, input logic [31:0] b, input logic [31:0] j,
                           input logic [31:0] t, input logic [31:0] exp_pc,
                           input logic exp_mis, input bit do_push);
    exp_ir = exp_ir + 1'b1;
    if (do_push) push_exp(exp_pc);
    sel = s; br_t = b; jmp_t = j; trap_v = t;
    commit = 1'b1;
    @(posedge clk);
    #1 commit = 1'b0;
    @(negedge clk);
    check("misalign pulse", 64'(misalign_exc), 64'(exp_mis));
    @(negedge clk);
    check("misalign clear", 64'(misalign_exc), 64'd0);
  endtask

  initial begin
    logic [31:0] p;
    rst_n = 1'b0; rdy = 1'b1; sel = 2'b00; br_t = '0; jmp_t = '0;
    trap_v = '0; commit = 1'b0; stall = 1'b0;
    repeat (3) @(negedge clk);
    check("rst imem_req", 64'(imem_req), 64'd0);
    check("rst inst_valid", 64'(inst_valid), 64'd0);
    check("rst inst", 64'(inst), 64'h13);
    check("rst pc", 64'(pc), 64'h0);
    check("rst misalign", 64'(misalign_exc), 64'd0);
    check("rst instret", 64'(instret), 64'd0);

    push_exp(32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first fetch req", 64'(imem_req), 64'd1);
    check("first fetch addr", 64'(imem_addr), 64'h0);
    check("first fetch valid", 64'(inst_valid), 64'd0);
    wait_valid();

    // Sequential commit with memory withholding ready for three cycles.
    rdy = 1'b0;
    exp_ir = exp_ir + 1'b1;
    push_exp(32'h4);
    sel = 2'b00; commit = 1'b1;
    @(posedge clk);
    #1 commit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wait req", 64'(imem_req), 64'd1);
      check("wait addr", 64'(imem_addr), 64'h4);
      check("wait valid", 64'(inst_valid), 64'd0);
      check("wait inst held", 64'(inst), 64'h0050_0093);
    end
    rdy = 1'b1;
    wait_valid();

    do_commit(2'b01, 32'h100, 32'h0, 32'h0, 32'h100, 1'b0, 1'b1);
    wait_valid();
    do_commit(2'b10, 32'h0, 32'h203, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
    wait_valid();
    do_commit(2'b11, 32'h0, 32'h0, 32'h8000_0103, 32'h8000_0100, 1'b0, 1'b1);
    wait_valid();

    // Commit held together with stall must not advance.
    sel = 2'b00; commit = 1'b1; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall pc", 64'(pc), 64'h8000_0100);
      check("stall instret", 64'(instret), 64'd4);
      check("stall valid", 64'(inst_valid), 64'd1);
    end
    stall = 1'b0;
    exp_ir = exp_ir + 1'b1;
    push_exp(32'h8000_0104);
    @(posedge clk);
    #1 commit = 1'b0;
    wait_valid();

    do_commit(2'b01, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b1);
    wait_valid();
    do_commit(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    wait_valid();

    // Nine more sequential commits take the 4-bit counter from 7 through wrap to 0.
    p = 32'h0;
    for (int i = 0; i < 9; i++) begin
      p = p + 32'h4;
      do_commit(2'b00, 32'h0, 32'h0, 32'h0, p, 1'b0, 1'b1);
      wait_valid();
    end
    check("instret wrapped", 64'(instret), 64'd0);

    // Park in FETCH at 0x40, then reset between clock edges.
    rdy = 1'b0;
    do_commit(2'b01, 32'h40, 32'h0, 32'h0, 32'h40, 1'b0, 1'b0);
    check("pre-reset addr", 64'(imem_addr), 64'h40);
    check("pre-reset req", 64'(imem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst req", 64'(imem_req), 64'd0);
    check("async rst pc", 64'(pc), 64'h0);
    check("async rst inst", 64'(inst), 64'h13);
    check("async rst instret", 64'(instret), 64'd0);
    check("async rst valid", 64'(inst_valid), 64'd0);
    @(negedge clk);
    exp_ir = '0;
    rdy = 1'b1;
    push_exp(32'h0);
    rst_n = 1'b1;
    wait_valid();
    @(negedge clk);
    check("scoreboard drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
